// File: rtl/draw_circle_pipe.sv
// Circle/ring overlay for the VGA chain: frame-latched parameters, 3-stage
// pipeline with delay-matched timing and pixel data.
module draw_circle_pipe #(
  parameter int unsigned RAD_W     = 8,
  parameter int unsigned THICK     = 3,
  parameter int unsigned DEF_X     = 512,
  parameter int unsigned DEF_Y     = 384,
  parameter int unsigned DEF_R     = 20,
  parameter logic [11:0] DEF_COLOR = 12'hf0f
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [11:0]      hcount_in,
  input  logic [11:0]      vcount_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             hblnk_in,
  input  logic             vblnk_in,
  input  logic [11:0]      rgb_in,
  input  logic [11:0]      xpos_in,
  input  logic [11:0]      ypos_in,
  input  logic [RAD_W-1:0] radius_in,
  input  logic [11:0]      color_in,
  input  logic             mode_in,
  input  logic             enable_in,
  output logic [11:0]      hcount_out,
  output logic [11:0]      vcount_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             hblnk_out,
  output logic             vblnk_out,
  output logic [11:0]      rgb_out,
  output logic [11:0]      xpos_out,
  output logic [11:0]      ypos_out,
  output logic [RAD_W-1:0] radius_out
);

  localparam int unsigned R2_W  = 2 * RAD_W;
  localparam int unsigned CMP_W = (R2_W > 25) ? R2_W : 25;
  localparam logic [RAD_W-1:0] THICK_R = RAD_W'(THICK);

  logic [11:0]      sh_x, sh_y, sh_c;
  logic [RAD_W-1:0] sh_r;
  logic             sh_m, sh_e;
  logic             vblnk_d, armed, load;

  // armed blocks a load on the first edge after reset, so a vblank already
  // in progress at release is not mistaken for a rising edge.
  assign load = armed & vblnk_in & ~vblnk_d;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      vblnk_d <= 1'b0;
      armed   <= 1'b0;
      sh_x    <= 12'(DEF_X);
      sh_y    <= 12'(DEF_Y);
      sh_r    <= RAD_W'(DEF_R);
      sh_c    <= DEF_COLOR;
      sh_m    <= 1'b0;
      sh_e    <= 1'b1;
    end else begin
      vblnk_d <= vblnk_in;
      armed   <= 1'b1;
      if (load) begin
        sh_x <= xpos_in;
        sh_y <= ypos_in;
        sh_r <= radius_in;
        sh_c <= color_in;
        sh_m <= mode_in;
        sh_e <= enable_in;
      end
    end
  end

  assign xpos_out   = sh_x;
  assign ypos_out   = sh_y;
  assign radius_out = sh_r;

  logic [RAD_W-1:0] r_inner;
  logic             inner_c;
  logic [R2_W-1:0]  r2_q, ri2_q;
  logic             inner_q, draw_q, mode_q;
  logic [11:0]      color_q;

  assign inner_c = sh_r > THICK_R;
  assign r_inner = sh_r - THICK_R;

  // Parameters used by stage 3 lag the shadows by one clock, so pixels in
  // flight at the load edge still finish with the previous frame's values.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r2_q    <= '0;
      ri2_q   <= '0;
      inner_q <= 1'b0;
      draw_q  <= 1'b0;
      mode_q  <= 1'b0;
      color_q <= '0;
    end else begin
      r2_q    <= sh_r * sh_r;
      ri2_q   <= inner_c ? r_inner * r_inner : '0;
      inner_q <= inner_c;
      draw_q  <= sh_e & (sh_r != '0);
      mode_q  <= sh_m;
      color_q <= sh_c;
    end
  end

  // timing bundle: {hcount, vcount, hsync, vsync, hblnk, vblnk}
  logic [27:0]        tim_s1, tim_s2;
  logic [11:0]        rgb_s1, rgb_s2;
  logic signed [12:0] dx_s1, dy_s1;
  logic [11:0]        adx, ady;
  logic [23:0]        dx2_s2, dy2_s2;
  logic [24:0]        d2;
  logic [CMP_W-1:0]   d2_e, r2_e, ri2_e;
  logic               hit_c;

  assign adx = dx_s1[12] ? 12'(-dx_s1) : 12'(dx_s1);
  assign ady = dy_s1[12] ? 12'(-dy_s1) : 12'(dy_s1);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      tim_s1 <= '0;
      rgb_s1 <= '0;
      dx_s1  <= '0;
      dy_s1  <= '0;
      tim_s2 <= '0;
      rgb_s2 <= '0;
      dx2_s2 <= '0;
      dy2_s2 <= '0;
    end else begin
      tim_s1 <= {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
      rgb_s1 <= rgb_in;
      dx_s1  <= signed'({1'b0, hcount_in}) - signed'({1'b0, sh_x});
      dy_s1  <= signed'({1'b0, vcount_in}) - signed'({1'b0, sh_y});
      tim_s2 <= tim_s1;
      rgb_s2 <= rgb_s1;
      dx2_s2 <= adx * adx;
      dy2_s2 <= ady * ady;
    end
  end

  assign d2    = {1'b0, dx2_s2} + {1'b0, dy2_s2};
  assign d2_e  = CMP_W'(d2);
  assign r2_e  = CMP_W'(r2_q);
  assign ri2_e = CMP_W'(ri2_q);
  assign hit_c = draw_q & ~tim_s2[1] & ~tim_s2[0] & (d2_e <= r2_e)
               & ~(mode_q & inner_q & (d2_e <= ri2_e));

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} <= tim_s2;
      rgb_out <= hit_c ? color_q : rgb_s2;
    end
  end

endmodule

// File: tb/tb_draw_circle_pipe.sv
// Directed + randomized bench for draw_circle_pipe against a geometric model
// with frame-latched parameters and a 3-clock output queue.
module tb_draw_circle_pipe;

  localparam int THICK = 3;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [11:0] hcount_in, vcount_in, rgb_in, xpos_in, ypos_in, color_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in, mode_in, enable_in;
  logic [7:0]  radius_in;
  logic [11:0] hcount_out, vcount_out, rgb_out, xpos_out, ypos_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [7:0]  radius_out;

  draw_circle_pipe #(
    .RAD_W(8), .THICK(THICK), .DEF_X(512), .DEF_Y(384), .DEF_R(20),
    .DEF_COLOR(12'hf0f)
  ) dut (
    .clk_in(clk_in), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
    .xpos_in(xpos_in), .ypos_in(ypos_in), .radius_in(radius_in),
    .color_in(color_in), .mode_in(mode_in), .enable_in(enable_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out),
    .xpos_out(xpos_out), .ypos_out(ypos_out), .radius_out(radius_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  // active (frame-latched) parameters as seen by the renderer
  int mx, my, mr, mc, mm, me;
  bit mprev;
  logic [39:0] q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mx = 512; my = 384; mr = 20; mc = 'hf0f; mm = 0; me = 1;
    mprev = 1'b1;   // a vblank already high at release is not a rising edge
    q.delete();
  endtask

  function automatic logic [11:0] model_rgb(input logic [11:0] h, input logic [11:0] v,
                                            input logic hb, input logic vb,
                                            input logic [11:0] rgb);
    longint dx, dy, d2, rin;
    bit hole, hit;
    dx   = longint'(h) - mx;
    dy   = longint'(v) - my;
    d2   = dx * dx + dy * dy;
    rin  = mr - THICK;
    hole = (mm != 0) && (mr > THICK) && (d2 <= rin * rin);
    hit  = (me != 0) && (mr != 0) && !hb && !vb && (d2 <= longint'(mr) * mr) && !hole;
    return hit ? 12'(mc) : rgb;
  endfunction

  task automatic set_req(input int x, input int y, input int r, input int c,
                         input bit m, input bit e);
    xpos_in = 12'(x); ypos_in = 12'(y); radius_in = 8'(r);
    color_in = 12'(c); mode_in = m; enable_in = e;
  endtask

  task automatic drive(input logic [11:0] h, input logic [11:0] v,
                       input logic hb, input logic vb);
    logic [39:0] e;
    hcount_in = h; vcount_in = v; hblnk_in = hb; vblnk_in = vb;
    hsync_in = 1'($urandom); vsync_in = 1'($urandom); rgb_in = 12'($urandom);
    @(posedge clk_in);
    e = {h, v, hsync_in, vsync_in, hb, vb, model_rgb(h, v, hb, vb, rgb_in)};
    q.push_back(e);
    if (vb && !mprev) begin
      mx = int'(xpos_in); my = int'(ypos_in); mr = int'(radius_in);
      mc = int'(color_in); mm = int'(mode_in); me = int'(enable_in);
    end
    mprev = vb;
    #1;
    if (q.size() == 3) begin
      e = q.pop_front();
      chk("pixel", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out}, e);
    end
    chk("shadow", {xpos_out, ypos_out, radius_out}, {12'(mx), 12'(my), 8'(mr)});
  endtask

  task automatic frame_load();
    drive(12'd0, 12'd0, 1'b1, 1'b1);
    drive(12'd0, 12'd0, 1'b1, 1'b1);
  endtask

  task automatic near(input int n);
    int h, v;
    for (int i = 0; i < n; i++) begin
      h = mx + int'($urandom_range(0, 2 * mr + 6)) - mr - 3;
      v = my + int'($urandom_range(0, 2 * mr + 6)) - mr - 3;
      drive(12'(h), 12'(v), ($urandom_range(0, 7) == 0), 1'b0);
    end
  endtask

  task automatic check_in_reset();
    chk("rst_pipe", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out}, 40'h0);
    chk("rst_shadow", {xpos_out, ypos_out, radius_out}, {12'd512, 12'd384, 8'd20});
  endtask

  initial begin
    rst = 1'b1;
    hcount_in = '0; vcount_in = '0; hsync_in = 0; vsync_in = 0;
    hblnk_in = 0; vblnk_in = 0; rgb_in = '0;
    set_req(512, 384, 20, 'hf0f, 0, 1);
    #3 check_in_reset();
    @(posedge clk_in);
    @(negedge clk_in) rst = 1'b0;
    model_reset();

    // defaults, boundary of the R=20 disc
    drive(12'd512, 12'd384, 0, 0);
    drive(12'd532, 12'd384, 0, 0);
    drive(12'd533, 12'd384, 0, 0);
    drive(12'd492, 12'd384, 0, 0);
    drive(12'd491, 12'd384, 0, 0);
    drive(12'd512, 12'd404, 0, 0);
    drive(12'd512, 12'd405, 0, 0);
    near(40);

    // request changed mid-frame: no effect until the vblank edge
    set_req(100, 100, 10, 'h0f0, 0, 1);
    drive(12'd512, 12'd384, 0, 0);
    drive(12'd532, 12'd384, 0, 0);
    near(10);
    frame_load();
    drive(12'd100, 12'd110, 0, 0);
    drive(12'd100, 12'd111, 0, 0);
    drive(12'd110, 12'd100, 0, 0);
    near(20);

    // ring mode
    set_req(300, 200, 20, 'h00f, 1, 1);
    drive(12'd10, 12'd10, 0, 0);
    frame_load();
    drive(12'd320, 12'd200, 0, 0);
    drive(12'd318, 12'd200, 0, 0);
    drive(12'd317, 12'd200, 0, 0);
    drive(12'd300, 12'd200, 0, 0);
    near(40);
    set_req(300, 200, 2, 'h00f, 1, 1);
    drive(12'd10, 12'd10, 0, 0);
    frame_load();
    drive(12'd300, 12'd200, 0, 0);
    drive(12'd302, 12'd200, 0, 0);
    near(10);

    // clipping at the screen edge
    set_req(5, 0, 10, 'hfff, 0, 1);
    drive(12'd10, 12'd10, 0, 0);
    frame_load();
    for (int h = 0; h <= 16; h++) drive(12'(h), 12'd0, 0, 0);
    for (int h = 4086; h <= 4095; h++) drive(12'(h), 12'd0, 0, 0);
    drive(12'd5, 12'd0, 1, 0);
    drive(12'd5, 12'd3, 1, 0);
    near(20);

    // disabled, then zero radius
    set_req(600, 300, 30, 'h123, 0, 0);
    drive(12'd10, 12'd10, 0, 0);
    frame_load();
    drive(12'd600, 12'd300, 0, 0);
    near(15);
    set_req(600, 300, 0, 'h123, 0, 1);
    drive(12'd10, 12'd10, 0, 0);
    frame_load();
    drive(12'd600, 12'd300, 0, 0);
    near(5);

    // randomized frames
    for (int f = 0; f < 12; f++) begin
      set_req(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
              int'($urandom_range(0, 40)), int'($urandom_range(0, 4095)),
              1'($urandom), ($urandom_range(0, 5) != 0));
      near(10);
      drive(12'd1, 12'd1, 0, 0);
      frame_load();
      near(40);
    end

    // asynchronous reset between edges during active video
    set_req(400, 400, 30, 'h0ff, 0, 1);
    drive(12'd1, 12'd1, 0, 0);
    frame_load();
    near(6);
    rst = 1'b1;
    #1 check_in_reset();
    @(posedge clk_in);
    #1 check_in_reset();

    // release with vblank already high: no load on that vblank
    hblnk_in = 1; vblnk_in = 1;
    @(negedge clk_in) rst = 1'b0;
    model_reset();
    drive(12'd0, 12'd0, 1, 1);
    drive(12'd0, 12'd0, 1, 1);
    drive(12'd0, 12'd0, 1, 1);
    drive(12'd512, 12'd384, 0, 0);
    drive(12'd532, 12'd384, 0, 0);
    drive(12'd533, 12'd384, 0, 0);
    near(10);
    chk("no_load_after_rst", {xpos_out, radius_out}, {12'd512, 8'd20});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
